// File: rtl/rr_mux16_arbiter_pkg.sv
// Shared types and constants for the round-robin 16:1 mux arbiter.
package rr_mux16_arbiter_pkg;

   localparam int unsigned N_REQ = 16;
   localparam int unsigned SEL_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Index of the lowest set bit; zero when no bit is set.
   function automatic logic [SEL_W-1:0] first_one(input logic [N_REQ-1:0] v);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (v[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_mux16_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
interface rr_mux16_arbiter_if;
   import rr_mux16_arbiter_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] w;
   logic [SEL_W-1:0] s;
   logic [N_REQ-1:0] gnt;
   logic             valid;
   logic             f;

   modport master (output req, output w, input s, input gnt, input valid, input f);
   modport slave  (input req, input w, output s, output gnt, output valid, output f);

endinterface

// File: rtl/rr_mux16_arbiter_mux16_1bit.sv
// 16:1 single-bit mux built from two 8:1 halves and a final 2:1 stage on s[3].
module mux16_1bit
   import rr_mux16_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] w,
   input  logic [SEL_W-1:0] s,
   output logic             y
);

   logic [7:0] w_lo;
   logic [7:0] w_hi;
   logic       y_lo;
   logic       y_hi;

   always_comb begin
      w_lo = w[7:0];
      w_hi = w[15:8];
      y_lo = w_lo[s[2:0]];
      y_hi = w_hi[s[2:0]];
      y    = s[3] ? y_hi : y_lo;
   end

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter sharing one 16:1 single-bit mux; bounded hold of MAX_HOLD cycles per grant.
module rr_mux16_arbiter
   import rr_mux16_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   rr_mux16_arbiter_if.slave  bus
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] s_q, s_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]   pick_off;
   logic [SEL_W-1:0]   pick_idx;
   logic               any_req;
   logic               hold_done;
   logic               mux_y;

   // Rotate so bit 0 is the requester at ptr, find first one, then map back modulo 16.
   always_comb begin
      req_dbl  = {bus.req, bus.req} >> ptr_q;
      req_rot  = req_dbl[N_REQ-1:0];
      pick_off = first_one(req_rot);
      pick_idx = ptr_q + pick_off;
      any_req  = |bus.req;
   end

   assign hold_done = (cnt_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      s_d     = s_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               s_d     = pick_idx;
               gnt_d   = N_REQ'(1) << pick_idx;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Voluntary or forced release both rotate priority past the grantee.
            if (!bus.req[s_q] || hold_done) begin
               gnt_d   = '0;
               valid_d = 1'b0;
               ptr_d   = s_q + SEL_W'(1);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         s_q     <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         s_q     <= s_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   mux16_1bit u_mux (
      .w (bus.w),
      .s (s_q),
      .y (mux_y)
   );

   assign bus.s     = s_q;
   assign bus.gnt   = gnt_q;
   assign bus.valid = valid_q;
   assign bus.f     = valid_q & mux_y;

endmodule
